// File: rtl/oled_frame_sequencer_if.sv
// Sequencer-side bus bundle: image controller, init ROM, transmitter handshake and status.
interface oled_frame_sequencer_if;
  logic       enable;
  logic [9:0] byte_counter;
  logic [7:0] pixel_data;
  logic [4:0] cmd_index;
  logic [7:0] cmd_byte;
  logic [7:0] tx_data;
  logic       tx_dc;
  logic       tx_valid;
  logic       tx_ready;
  logic       frame_done;
  logic [7:0] frame_count;
  logic       busy;

  modport master (
    input  enable, pixel_data, cmd_byte, tx_ready,
    output byte_counter, cmd_index, tx_data, tx_dc, tx_valid, frame_done, frame_count, busy
  );

  modport slave (
    output enable, pixel_data, cmd_byte, tx_ready,
    input  byte_counter, cmd_index, tx_data, tx_dc, tx_valid, frame_done, frame_count, busy
  );
endinterface

// File: rtl/oled_frame_sequencer.sv
// 128x64 page-mode OLED stream sequencer: power-up delay, ROM init commands, then
// per-frame address-window prefix followed by the pixel bytes, over a valid/ready link.
module oled_frame_sequencer #(
  parameter int unsigned POWERUP_CYCLES = 16,
  parameter int unsigned INIT_LEN       = 25,
  parameter int unsigned FRAME_GAP      = 1000,
  parameter int unsigned FRAME_BYTES    = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  oled_frame_sequencer_if.master        bus
);

  localparam int unsigned TMR_MAX = (POWERUP_CYCLES > FRAME_GAP) ? POWERUP_CYCLES : FRAME_GAP;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);
  localparam int unsigned WIN_LEN = 6;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT,
    S_HOLD,
    S_WINDOW,
    S_STREAM,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic            r_fetched;
  logic [2:0]      r_win_idx;
  logic [9:0]      r_byte_counter;
  logic [4:0]      r_cmd_index;
  logic [7:0]      r_tx_data;
  logic            r_tx_dc;
  logic            r_tx_valid;
  logic            r_frame_done;
  logic [7:0]      r_frame_count;
  logic            r_busy;

  logic [7:0]      w_src_data;
  logic            w_src_dc;

  // Fixed column 0..127 / page 0..7 address window
  function automatic logic [7:0] window_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    window_byte = 8'h21;
      3'd1:    window_byte = 8'h00;
      3'd2:    window_byte = 8'h7F;
      3'd3:    window_byte = 8'h22;
      3'd4:    window_byte = 8'h00;
      default: window_byte = 8'h07;
    endcase
  endfunction

  // Byte source for the current phase
  always_comb begin
    w_src_data = bus.cmd_byte;
    w_src_dc   = 1'b0;
    if (r_state == S_WINDOW) begin
      w_src_data = window_byte(r_win_idx);
    end else if (r_state == S_STREAM) begin
      w_src_data = bus.pixel_data;
      w_src_dc   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_POWERUP;
      r_timer        <= '0;
      r_fetched      <= 1'b0;
      r_win_idx      <= '0;
      r_byte_counter <= '0;
      r_cmd_index    <= '0;
      r_tx_data      <= 8'h00;
      r_tx_dc        <= 1'b0;
      r_tx_valid     <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frame_count  <= '0;
      r_busy         <= 1'b1;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_POWERUP: begin
          if (r_timer == TW'(POWERUP_CYCLES - 1)) begin
            r_timer <= '0;
            r_state <= S_INIT;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        // Shared byte engine: address set -> source registers -> capture -> handshake
        S_INIT, S_WINDOW, S_STREAM: begin
          if (r_tx_valid) begin
            if (bus.tx_ready) begin
              r_tx_valid <= 1'b0;
              case (r_state)
                S_INIT: begin
                  if (r_cmd_index == 5'(INIT_LEN - 1)) begin
                    r_state <= S_HOLD;
                    r_busy  <= 1'b0;
                  end else begin
                    r_cmd_index <= r_cmd_index + 5'd1;
                  end
                end
                S_WINDOW: begin
                  if (r_win_idx == 3'(WIN_LEN - 1)) begin
                    r_win_idx <= '0;
                    r_state   <= S_STREAM;
                  end else begin
                    r_win_idx <= r_win_idx + 3'd1;
                  end
                end
                default: begin
                  if (r_byte_counter == 10'(FRAME_BYTES - 1)) begin
                    r_byte_counter <= '0;
                    r_frame_done   <= 1'b1;
                    r_frame_count  <= r_frame_count + 8'd1;
                    r_timer        <= '0;
                    r_state        <= S_GAP;
                  end else begin
                    r_byte_counter <= r_byte_counter + 10'd1;
                  end
                end
              endcase
            end
          end else if (!r_fetched) begin
            r_fetched <= 1'b1;
          end else begin
            r_fetched  <= 1'b0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_src_data;
            r_tx_dc    <= w_src_dc;
          end
        end

        S_HOLD: begin
          if (bus.enable) begin
            r_win_idx <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_WINDOW;
          end
        end

        S_GAP: begin
          if (r_timer == TW'(FRAME_GAP - 1)) begin
            r_timer <= '0;
            if (bus.enable) begin
              r_state <= S_WINDOW;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_HOLD;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        default: r_state <= S_POWERUP;
      endcase
    end
  end

  assign bus.byte_counter = r_byte_counter;
  assign bus.cmd_index    = r_cmd_index;
  assign bus.tx_data      = r_tx_data;
  assign bus.tx_dc        = r_tx_dc;
  assign bus.tx_valid     = r_tx_valid;
  assign bus.frame_done   = r_frame_done;
  assign bus.frame_count  = r_frame_count;
  assign bus.busy         = r_busy;

endmodule

// File: doc/oled_frame_sequencer.md
Name: oled_frame_sequencer

Overview:
- Sequences the 128x64 page-mode OLED stream for the Tamagotchi display.
- After power-up it sends the panel init commands from an external command ROM. Each frame then starts with a fixed address-window prefix, followed by all 1024 pixel bytes.
- It drives byte_counter into the image controller, which returns pixel data one cycle later. It feeds the serial transmitter over a valid/ready handshake.

Parameters:
- POWERUP_CYCLES, 16, idle cycles after reset before the first command.
- INIT_LEN, 25, number of init command bytes read from the command ROM (1..32).
- FRAME_GAP, 1000, idle cycles between the end of one frame and the next window prefix (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  frame streaming permitted
- byte_counter  out  10  pixel byte address to the image controller
- pixel_data  in  8  image controller data, valid one cycle after byte_counter
- cmd_index  out  5  init ROM address
- cmd_byte  in  8  init ROM data, valid one cycle after cmd_index
- tx_data  out  8  byte to the transmitter
- tx_dc  out  1  0 = command, 1 = display data
- tx_valid  out  1  tx_data/tx_dc valid
- tx_ready  in  1  transmitter accepts the byte
- frame_done  out  1  one-cycle pulse per completed frame
- frame_count  out  8  completed frames, wraps 255->0
- busy  out  1  high in every state except HOLD

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state including mid-byte or mid-frame:
  - state POWERUP, timer cleared.
  - byte_counter=0, cmd_index=0, tx_data=0x00, tx_dc=0, tx_valid=0, frame_done=0, frame_count=0, busy=1.
- States:
  - POWERUP: count POWERUP_CYCLES cycles, then go to INIT.
  - INIT: send cmd_byte for cmd_index 0..INIT_LEN-1 with tx_dc=0, then go to HOLD.
  - HOLD: busy=0. Stay until enable=1, then go to WINDOW.
  - WINDOW: send the fixed commands 0x21,0x00,0x7F,0x22,0x00,0x07 with tx_dc=0, then go to STREAM.
  - STREAM: send pixel_data for byte_counter 0..1023 with tx_dc=1, then go to GAP.
  - GAP: count FRAME_GAP cycles, then go to WINDOW if enable=1, else HOLD.
- Per-byte timing, identical in INIT, WINDOW and STREAM:
  - Address (byte_counter/cmd_index) is registered on entry to the phase or on the accepting edge.
  - The source registers its data on the next edge.
  - The sequencer captures it into tx_data on the following edge and raises tx_valid.
  - So tx_valid is low for exactly 2 cycles before every byte, including the first byte of each phase.
- Handshake:
  - A transfer occurs on an edge where tx_valid=1 and tx_ready=1.
  - tx_data/tx_dc stay stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops without a transfer, except on reset.
  - tx_valid is never asserted in POWERUP, HOLD or GAP.
- byte_counter:
  - Changes only on an accepted STREAM byte: +1, or 1023->0 on the last byte.
  - Holds 0 outside STREAM.
- cmd_index:
  - +1 per accepted INIT byte.
  - Holds INIT_LEN-1 after INIT finishes.
  - It is not reread after INIT.
- frame_done / frame_count:
  - frame_done is high for exactly the one cycle after the 1024th accepted data byte.
  - frame_count increments on that same edge.
- enable:
  - Sampled only in HOLD and at GAP expiry.
  - Dropping enable mid-frame does not truncate the frame.
- tx_ready held high: each byte occupies 3 cycles, so a frame is 3*(6+1024) cycles plus FRAME_GAP.

Test Plan:
- Test parameters: POWERUP_CYCLES=4, INIT_LEN=3, FRAME_GAP=5.
- Reset, then release with ROM {0xAE,0x8D,0xAF} and tx_ready=1 -> tx_valid stays low for 4 cycles plus the 2-cycle fetch. Then 0xAE,0x8D,0xAF are sent with tx_dc=0, each separated by 2 low cycles. busy falls in HOLD.
- enable=1, tx_ready=1, pixel_data=byte_counter[7:0] ->
  - 0x21,0x00,0x7F,0x22,0x00,0x07 are sent with tx_dc=0.
  - Then 1024 bytes are sent with tx_dc=1, values 0x00..0xFF repeating.
  - frame_done pulses once, frame_count=1.
  - The next WINDOW starts after 5 GAP cycles.
- Backpressure: tx_ready=0 for 10 cycles while data byte 0x05 is valid -> tx_data=0x05 and tx_valid=1 stay stable, byte_counter stays 5. Accepted on the first tx_ready=1 edge.
- enable dropped at byte 500 -> the frame completes all 1024 bytes, then GAP, then HOLD with busy=0 and no further tx_valid.
- rst_n=0 for one cycle at STREAM byte 700 with tx_valid=1 -> all outputs return to reset values next cycle, and the full POWERUP/INIT sequence repeats.
- 256 frames with FRAME_GAP=1 -> frame_count wraps to 0 on the 256th frame_done.
